// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: RV32I ldst funct3 codes and
// the encoding of the outstanding-read owner register.
package dmem_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e     own;
        logic [2:0] code;
        logic [1:0] lane;
    } rd_own_t;

endpackage

// File: rtl/dmem_arbiter_ldst_lane.sv
// Byte-lane handling: store byte enables / replicated write data, and load
// lane extraction with sign or zero extension.
module ldst_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  ld_code_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
        case (st_size_i)
            2'b00: begin
                be_o    = 4'b0001 << st_lane_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = st_lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_lane_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = ld_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_code_i)
            LDST_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            LDST_BU: ld_data_o = {24'd0, ld_byte};
            LDST_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            LDST_HU: ld_data_o = {16'd0, ld_half};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter: CPU MA stage vs. debug monitor, CPU priority
// with bounded monitor wait. Optional misalign trap via DMEM_MISALIGN_TRAP_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADR_W        = 12,
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_ld_ma,
    input  logic             cmd_st_ma,
    input  logic [2:0]       ldst_code_ma,
    input  logic [31:0]      rd_data_ma,
    input  logic [31:0]      st_data_ma,
    input  logic             cpu_stat_ma,
    output logic             stall_ma,
    output logic [31:0]      ld_data_wb,
    output logic             ld_valid_wb,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [ADR_W-1:0] dbg_adr,
    input  logic [31:0]      dbg_wdata,
    output logic             dbg_ack,
    output logic [31:0]      dbg_rdata,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_re,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             misalign_ma
);
    localparam logic [7:0] MAX_WAIT = 8'(DBG_MAX_WAIT);

    rd_own_t     own_q, own_d;
    logic [7:0]  wait_q, wait_d;
    logic        wack_q, wack_d;

    logic        cpu_req, cpu_ld, cpu_gnt, cpu_mis;
    logic        dbg_v, dbg_gnt, force_dbg;
    logic [31:0] adr_al;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_ld;
    logic        unused_adr;

    // Reset also masks requests so every output sits at its reset value.
    assign cpu_req   = (cmd_ld_ma | cmd_st_ma) & cpu_stat_ma & ~rst;
    assign cpu_ld    = cmd_ld_ma;
    assign dbg_ack   = wack_q | (own_q.own == OWN_DBG);
    assign dbg_v     = dbg_req & ~dbg_ack & ~rst;
    assign force_dbg = dbg_v & (wait_q == MAX_WAIT);
    assign cpu_gnt   = cpu_req & ~force_dbg;
    assign dbg_gnt   = dbg_v & ~cpu_gnt;
    assign stall_ma  = cpu_req & ~cpu_gnt;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign adr_al  = rd_data_ma;
    assign cpu_mis = cpu_gnt &
                     (((ldst_code_ma[1:0] == 2'b01) & rd_data_ma[0]) |
                      ((ldst_code_ma[1:0] == 2'b10) & (rd_data_ma[1:0] != 2'b00)));
`else
    always_comb begin
        adr_al = rd_data_ma;
        case (ldst_code_ma[1:0])
            2'b01:   adr_al[0]   = 1'b0;
            2'b10:   adr_al[1:0] = 2'b00;
            default: ;
        endcase
    end
    assign cpu_mis = 1'b0;
`endif
    assign misalign_ma = cpu_mis;
    assign unused_adr  = ^adr_al[31:ADR_W+2];

    ldst_lane u_lane (
        .st_size_i (ldst_code_ma[1:0]),
        .st_lane_i (adr_al[1:0]),
        .st_data_i (st_data_ma),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .ld_code_i (own_q.code),
        .ld_lane_i (own_q.lane),
        .rdata_i   (mem_rdata),
        .ld_data_o (lane_ld)
    );

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        if (cpu_gnt && !cpu_mis) begin
            mem_re    = cpu_ld;
            mem_we    = ~cpu_ld;
            mem_adr   = adr_al[ADR_W+1:2];
            mem_be    = lane_be;
            mem_wdata = lane_wdata;
        end else if (dbg_gnt) begin
            mem_re    = ~dbg_we;
            mem_we    = dbg_we;
            mem_adr   = dbg_adr;
            mem_be    = 4'b1111;
            mem_wdata = dbg_wdata;
        end
    end

    always_comb begin
        own_d = '{own: OWN_NONE, code: 3'd0, lane: 2'd0};
        if (cpu_gnt && cpu_ld && !cpu_mis)
            own_d = '{own: OWN_CPU, code: ldst_code_ma, lane: adr_al[1:0]};
        else if (dbg_gnt && !dbg_we)
            own_d.own = OWN_DBG;
        wack_d = dbg_gnt & dbg_we;
        wait_d = wait_q;
        if (!dbg_v || dbg_gnt)
            wait_d = 8'd0;
        else if (wait_q != 8'hFF)
            wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q  <= '{own: OWN_NONE, code: 3'd0, lane: 2'd0};
            wait_q <= 8'd0;
            wack_q <= 1'b0;
        end else begin
            own_q  <= own_d;
            wait_q <= wait_d;
            wack_q <= wack_d;
        end
    end

    assign ld_valid_wb = (own_q.own == OWN_CPU);
    assign ld_data_wb  = ld_valid_wb ? lane_ld : 32'd0;
    assign dbg_rdata   = (own_q.own == OWN_DBG) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (default ADR_W/DBG_MAX_WAIT).
module tb_dmem_arbiter;
    localparam int ADR_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_ld_ma, cmd_st_ma, cpu_stat_ma;
    logic [2:0]       ldst_code_ma;
    logic [31:0]      rd_data_ma, st_data_ma;
    logic             stall_ma, ld_valid_wb;
    logic [31:0]      ld_data_wb;
    logic             dbg_req, dbg_we, dbg_ack;
    logic [ADR_W-1:0] dbg_adr;
    logic [31:0]      dbg_wdata, dbg_rdata;
    logic [ADR_W-1:0] mem_adr;
    logic             mem_re, mem_we, misalign_ma;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .ldst_code_ma(ldst_code_ma),
        .rd_data_ma(rd_data_ma), .st_data_ma(st_data_ma), .cpu_stat_ma(cpu_stat_ma),
        .stall_ma(stall_ma), .ld_data_wb(ld_data_wb), .ld_valid_wb(ld_valid_wb),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_adr(mem_adr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .misalign_ma(misalign_ma)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        cmd_ld_ma = 0; cmd_st_ma = 0; ldst_code_ma = 3'd0; cpu_stat_ma = 1;
        rd_data_ma = 0; st_data_ma = 0; dbg_req = 0; dbg_we = 0;
        dbg_adr = '0; dbg_wdata = 0; mem_rdata = 0;
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic cpu(input logic ld, input logic [2:0] code,
                       input logic [31:0] adr, input logic [31:0] sd);
        idle();
        cmd_ld_ma = ld; cmd_st_ma = ~ld; ldst_code_ma = code;
        rd_data_ma = adr; st_data_ma = sd;
    endtask

    initial begin
        idle();
        rst = 1;
        #3;
        chk("rst_stall", {31'd0, stall_ma}, 0);
        chk("rst_ldv",   {31'd0, ld_valid_wb}, 0);
        chk("rst_ack",   {31'd0, dbg_ack}, 0);
        chk("rst_re_we", {30'd0, mem_re, mem_we}, 0);
        chk("rst_mis",   {31'd0, misalign_ma}, 0);
        chk("rst_be",    {28'd0, mem_be}, 0);
        chk("rst_ldd",   ld_data_wb, 0);
        chk("rst_dbgrd", dbg_rdata, 0);
        cyc(); cyc();
        rst = 0;

        // LB at 0x103
        cyc(); cpu(1, 3'b000, 32'h103, 0); #3;
        chk("lb_re",    {31'd0, mem_re}, 1);
        chk("lb_adr",   {20'd0, mem_adr}, 32'h40);
        chk("lb_stall", {31'd0, stall_ma}, 0);
        cyc(); idle(); mem_rdata = 32'h80FF_0000; #3;
        chk("lb_vld",   {31'd0, ld_valid_wb}, 1);
        chk("lb_data",  ld_data_wb, 32'hFFFF_FF80);
        // LBU at 0x103
        cyc(); cpu(1, 3'b100, 32'h103, 0); #3;
        cyc(); idle(); mem_rdata = 32'h80FF_0000; #3;
        chk("lbu_data", ld_data_wb, 32'h0000_0080);
        // LHU at 0x102 -> upper half, zero-extended
        cyc(); cpu(1, 3'b101, 32'h102, 0); #3;
        cyc(); idle(); mem_rdata = 32'h80FF_0000; #3;
        chk("lhu_data", ld_data_wb, 32'h0000_80FF);
        chk("idle_vld", {31'd0, ld_valid_wb}, 1);
        cyc(); #3;
        chk("ldv_drop", {31'd0, ld_valid_wb}, 0);

        // SH 0x1234 at 0x102
        cyc(); cpu(0, 3'b001, 32'h102, 32'h0000_1234); #3;
        chk("sh_be",    {28'd0, mem_be}, 32'hC);
        chk("sh_wd",    mem_wdata, 32'h1234_1234);
        chk("sh_we_re", {30'd0, mem_we, mem_re}, 32'h2);
        chk("sh_stall", {31'd0, stall_ma}, 0);
        // SB 0xAB at 0x101
        cyc(); cpu(0, 3'b000, 32'h101, 32'hFFFF_FFAB); #3;
        chk("sb_be",    {28'd0, mem_be}, 32'h2);
        chk("sb_wd",    mem_wdata, 32'hABAB_ABAB);

        // Monitor read at 0x10, CPU idle
        cyc(); idle(); dbg_req = 1; dbg_adr = 12'h010; #3;
        chk("mrd_re",   {31'd0, mem_re}, 1);
        chk("mrd_adr",  {20'd0, mem_adr}, 32'h10);
        cyc(); mem_rdata = 32'hCAFE_BABE; #3;
        chk("mrd_ack",  {31'd0, dbg_ack}, 1);
        chk("mrd_data", dbg_rdata, 32'hCAFE_BABE);
        chk("mrd_ign",  {31'd0, mem_re}, 0);
        // Monitor write at 0x05
        cyc(); idle(); dbg_req = 1; dbg_we = 1; dbg_adr = 12'h005; dbg_wdata = 32'h5A5A_0001; #3;
        chk("mwr_we",   {31'd0, mem_we}, 1);
        chk("mwr_be",   {28'd0, mem_be}, 32'hF);
        chk("mwr_wd",   mem_wdata, 32'h5A5A_0001);
        chk("mwr_ack0", {31'd0, dbg_ack}, 0);
        cyc(); #3;
        chk("mwr_ack",  {31'd0, dbg_ack}, 1);
        chk("mwr_ign",  {31'd0, mem_we}, 0);

        // Starvation: CPU loads every cycle, monitor held; forced on 9th cycle
        for (int i = 1; i <= 10; i++) begin
            cyc(); cpu(1, 3'b010, 32'h100, 0); dbg_req = 1; dbg_adr = 12'h033; #3;
            chk($sformatf("starve_stall%0d", i), {31'd0, stall_ma}, (i == 9) ? 1 : 0);
            chk($sformatf("starve_adr%0d", i), {20'd0, mem_adr}, (i == 9) ? 32'h33 : 32'h40);
        end
        chk("starve_ack", {31'd0, dbg_ack}, 1);
        // Counter restarted: a fresh request is not forced before its 9th cycle
        cyc(); cpu(1, 3'b010, 32'h100, 0); dbg_req = 1; dbg_adr = 12'h033; #3;
        chk("wait_clr", {31'd0, stall_ma}, 0);
        cyc(); idle(); #3;

        // CPU halted: monitor granted immediately
        cyc(); cpu(1, 3'b010, 32'h100, 0); cpu_stat_ma = 0; dbg_req = 1; dbg_adr = 12'h077; #3;
        chk("halt_stall", {31'd0, stall_ma}, 0);
        chk("halt_adr",   {20'd0, mem_adr}, 32'h77);
        chk("halt_re",    {31'd0, mem_re}, 1);
        cyc(); idle(); #3;
        cyc(); #3;

        // Reset the cycle after a CPU load issue
        cyc(); cpu(1, 3'b010, 32'h100, 0); #3;
        chk("rl_re", {31'd0, mem_re}, 1);
        cyc(); idle(); rst = 1; mem_rdata = 32'h1111_2222; #3;
        chk("rl_vld",  {31'd0, ld_valid_wb}, 0);
        chk("rl_data", ld_data_wb, 0);
        chk("rl_outs", {27'd0, stall_ma, dbg_ack, mem_re, mem_we, misalign_ma}, 0);
        cyc(); rst = 0; #3;
        chk("rl_vld2", {31'd0, ld_valid_wb}, 0);
        chk("rl_ack2", {31'd0, dbg_ack}, 0);

        // LW at 0x102 and LH at 0x103
        cyc(); cpu(1, 3'b010, 32'h102, 0); #3;
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lw_mis", {31'd0, misalign_ma}, 1);
        chk("lw_re",  {31'd0, mem_re}, 0);
        cyc(); idle(); mem_rdata = 32'hDEAD_BEEF; #3;
        chk("lw_vld", {31'd0, ld_valid_wb}, 0);
        cyc(); cpu(1, 3'b001, 32'h103, 0); #3;
        chk("lh_mis", {31'd0, misalign_ma}, 1);
        chk("lh_re",  {31'd0, mem_re}, 0);
`else
        chk("lw_mis", {31'd0, misalign_ma}, 0);
        chk("lw_re",  {31'd0, mem_re}, 1);
        chk("lw_adr", {20'd0, mem_adr}, 32'h40);
        cyc(); idle(); mem_rdata = 32'hDEAD_BEEF; #3;
        chk("lw_vld",  {31'd0, ld_valid_wb}, 1);
        chk("lw_data", ld_data_wb, 32'hDEAD_BEEF);
        cyc(); cpu(1, 3'b001, 32'h103, 0); #3;
        chk("lh_re",  {31'd0, mem_re}, 1);
        cyc(); idle(); mem_rdata = 32'h80FF_0000; #3;
        chk("lh_data", ld_data_wb, 32'hFFFF_80FF);
`endif
        cyc(); idle(); #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
